// File: rtl/minmax_stream_reduce.sv
// minmax_stream_reduce: reduces a framed stream of elements to its minimum or
// maximum value, reporting the winning index, the element count (saturating)
// and a sticky overflow flag. One frame is in flight at a time.
module minmax_stream_reduce #(
    parameter int WIDTH     = 16,
    parameter bit IS_SIGNED = 1'b1,
    parameter int IDX_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mode,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [IDX_WIDTH-1:0] out_idx,
    output logic [IDX_WIDTH-1:0] out_cnt,
    output logic                 out_ovf
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [IDX_WIDTH-1:0] CNT_MAX = {IDX_WIDTH{1'b1}};
    localparam logic [IDX_WIDTH-1:0] CNT_ONE = {{(IDX_WIDTH-1){1'b0}}, 1'b1};

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_armed;
    logic                 r_mode;
    logic                 r_ovf;
    logic [WIDTH-1:0]     r_acc;
    logic [IDX_WIDTH-1:0] r_idx;
    logic [IDX_WIDTH-1:0] r_cnt;

    logic                 w_in_fire;
    logic                 w_out_fire;
    logic                 w_lt;
    logic                 w_gt;
    logic                 w_better;

    // in_ready stays low until the first clock edge after reset release;
    // both handshake outputs decode from registers only.
    assign in_ready   = r_armed & (r_state != ST_DONE);
    assign out_valid  = (r_state == ST_DONE);
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;

    assign out_data = r_acc;
    assign out_idx  = r_idx;
    assign out_cnt  = r_cnt;
    assign out_ovf  = r_ovf;

    // Strict comparison of the incoming element against the running extreme.
    always_comb begin
        w_lt = 1'b0;
        w_gt = 1'b0;
        if (IS_SIGNED) begin
            w_lt = ($signed(in_data) < $signed(r_acc));
            w_gt = ($signed(in_data) > $signed(r_acc));
        end else begin
            w_lt = (in_data < r_acc);
            w_gt = (in_data > r_acc);
        end
        w_better = r_mode ? w_gt : w_lt;
    end

    // Next-state logic for the frame FSM.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_in_fire) begin
                    w_state_nxt = in_last ? ST_DONE : ST_ACCUM;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (w_in_fire && in_last) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_ACCUM;
                end
            end
            ST_DONE: begin
                if (w_out_fire) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register plus the post-reset arming flag for in_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_armed <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_armed <= 1'b1;
        end
    end

    // Accumulator datapath: first beat loads, later beats keep the earliest
    // strictly-better element; the count saturates and flags overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc  <= {WIDTH{1'b0}};
            r_idx  <= {IDX_WIDTH{1'b0}};
            r_cnt  <= {IDX_WIDTH{1'b0}};
            r_mode <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_in_fire) begin
                        r_acc  <= in_data;
                        r_idx  <= {IDX_WIDTH{1'b0}};
                        r_cnt  <= CNT_ONE;
                        r_mode <= mode;
                        r_ovf  <= 1'b0;
                    end
                end
                ST_ACCUM: begin
                    if (w_in_fire) begin
                        if (w_better) begin
                            r_acc <= in_data;
                            r_idx <= r_cnt;
                        end
                        if (r_cnt == CNT_MAX) begin
                            r_ovf <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CNT_ONE;
                        end
                    end
                end
                default: begin
                    r_acc <= r_acc;
                end
            endcase
        end
    end

endmodule
